// File: rtl/rram_pulse_sequencer.sv
// ============================================================================
// Module   : rram_pulse_sequencer
// Function : Wishbone-programmed FORM/SET/RESET/READ pulse sequencer for the
//            RRAM test array. Optional program-and-verify loop: RRAM_VERIFY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rram_pulse_sequencer #(
   parameter int          ROWS       = 8,
   parameter int          COLS       = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          MAX_PULSES = 16
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   output logic [ROWS-1:0] row_sel,
   output logic [COLS-1:0] col_sel,
   output logic [1:0]      drv_mode,
   output logic            pulse_en,
   output logic            sense_en,
   input  logic            sense_in,
   output logic            irq
);

`ifdef RRAM_VERIFY_EN
   localparam bit c_VERIFY = 1'b1;
`else
   localparam bit c_VERIFY = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_PULSE   = 3'd2,
      S_SENSE   = 3'd3,
      S_RECOVER = 3'd4,
      S_VSENSE  = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t            r_state;
   logic [15:0]       r_cnt;
   logic              r_ack;
   logic [31:0]       r_dat;
   logic [1:0]        r_op;
   logic              r_irq_en;
   logic [7:0]        r_row;
   logic [7:0]        r_col;
   logic [15:0]       r_pulse_w;
   logic [7:0]        r_setup_w;
   logic [7:0]        r_recover_w;
   logic              r_busy;
   logic              r_done;
   logic              r_aborted;
   logic              r_addr_err;
   logic              r_verify_fail;
   logic [7:0]        r_pulses_used;
   logic              r_sense_bit;
   logic [ROWS-1:0]   r_row_sel;
   logic [COLS-1:0]   r_col_sel;
   logic [1:0]        r_drv_mode;
   logic              r_pulse_en;
   logic              r_sense_en;

   logic              w_hit, w_acc, w_wr, w_aligned;
   logic              w_wr_ctrl, w_wr_addr, w_wr_tim, w_wr_stat;
   logic              w_start, w_abort, w_abort_req, w_addr_bad, w_sense_ok;
   logic [1:0]        w_op_new;
   logic [15:0]       w_setup_ld, w_pulse_ld, w_rec_ld;
   logic [7:0]        w_pu_inc;
   logic [ROWS-1:0]   w_row_oh;
   logic [COLS-1:0]   w_col_oh;
   logic [31:0]       w_rd_val;

   assign w_hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   // Accept only when no ack is outstanding so acks can never be back-to-back.
   assign w_acc     = w_hit & ~r_ack;
   assign w_wr      = w_acc & wbs_we_i;
   assign w_aligned = (wbs_adr_i[1:0] == 2'b00);
   assign w_wr_ctrl = w_wr & w_aligned & (wbs_adr_i[3:2] == 2'd0);
   assign w_wr_addr = w_wr & w_aligned & (wbs_adr_i[3:2] == 2'd1);
   assign w_wr_tim  = w_wr & w_aligned & (wbs_adr_i[3:2] == 2'd2);
   assign w_wr_stat = w_wr & w_aligned & (wbs_adr_i[3:2] == 2'd3);

   assign w_abort_req = w_wr_ctrl & wbs_sel_i[0] & wbs_dat_i[3];
   assign w_abort     = w_abort_req & (r_state != S_IDLE);
   assign w_start     = w_wr_ctrl & wbs_sel_i[0] & wbs_dat_i[2] & ~w_abort_req &
                        (r_state == S_IDLE);
   assign w_op_new    = (w_wr_ctrl & wbs_sel_i[0] & ~r_busy) ? wbs_dat_i[1:0] : r_op;

   assign w_addr_bad  = (int'(r_row) >= ROWS) || (int'(r_col) >= COLS);
   assign w_row_oh    = {{(ROWS-1){1'b0}}, 1'b1} << r_row;
   assign w_col_oh    = {{(COLS-1){1'b0}}, 1'b1} << r_col;

   assign w_setup_ld  = (r_setup_w == 8'd0)    ? 16'd0 : {8'd0, r_setup_w} - 16'd1;
   assign w_pulse_ld  = (r_pulse_w == 16'd0)   ? 16'd0 : r_pulse_w - 16'd1;
   assign w_rec_ld    = (r_recover_w == 8'd0)  ? 16'd0 : {8'd0, r_recover_w} - 16'd1;
   assign w_pu_inc    = (r_pulses_used == 8'hFF) ? 8'hFF : r_pulses_used + 8'd1;
   // RESET programs a high-resistance state, so a verified RESET senses 0.
   assign w_sense_ok  = (r_op == 2'd2) ? ~sense_in : sense_in;

   always_comb begin
      w_rd_val = 32'd0;
      if (w_aligned) begin
         case (wbs_adr_i[3:2])
            2'd0:    w_rd_val = {27'd0, r_irq_en, 2'b00, r_op};
            2'd1:    w_rd_val = {16'd0, r_col, r_row};
            2'd2:    w_rd_val = {r_recover_w, r_setup_w, r_pulse_w};
            default: w_rd_val = {15'd0, r_sense_bit, r_pulses_used, 3'd0, r_verify_fail,
                                 r_addr_err, r_aborted, r_done, r_busy};
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state       <= S_IDLE;
         r_cnt         <= 16'd0;
         r_ack         <= 1'b0;
         r_dat         <= 32'd0;
         r_op          <= 2'd0;
         r_irq_en      <= 1'b0;
         r_row         <= 8'd0;
         r_col         <= 8'd0;
         r_pulse_w     <= 16'd0;
         r_setup_w     <= 8'd0;
         r_recover_w   <= 8'd0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
         r_addr_err    <= 1'b0;
         r_verify_fail <= 1'b0;
         r_pulses_used <= 8'd0;
         r_sense_bit   <= 1'b0;
         r_row_sel     <= '0;
         r_col_sel     <= '0;
         r_drv_mode    <= 2'd0;
         r_pulse_en    <= 1'b0;
         r_sense_en    <= 1'b0;
      end else begin
         r_ack <= w_acc;
         r_dat <= (w_acc & ~wbs_we_i) ? w_rd_val : 32'd0;
         r_op  <= w_op_new;
         if (w_wr_ctrl & wbs_sel_i[0])
            r_irq_en <= wbs_dat_i[4];
         if (w_wr_addr & ~r_busy) begin
            if (wbs_sel_i[0]) r_row <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) r_col <= wbs_dat_i[15:8];
         end
         if (w_wr_tim & ~r_busy) begin
            if (wbs_sel_i[0]) r_pulse_w[7:0]  <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) r_pulse_w[15:8] <= wbs_dat_i[15:8];
            if (wbs_sel_i[2]) r_setup_w       <= wbs_dat_i[23:16];
            if (wbs_sel_i[3]) r_recover_w     <= wbs_dat_i[31:24];
         end
         if (w_wr_stat & wbs_sel_i[0] & wbs_dat_i[1])
            r_done <= 1'b0;

         if (w_abort) begin
            r_state    <= S_IDLE;
            r_row_sel  <= '0;
            r_col_sel  <= '0;
            r_drv_mode <= 2'd0;
            r_pulse_en <= 1'b0;
            r_sense_en <= 1'b0;
            r_aborted  <= 1'b1;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_start) begin
                     r_aborted     <= 1'b0;
                     r_verify_fail <= 1'b0;
                     r_pulses_used <= 8'd0;
                     r_addr_err    <= w_addr_bad;
                     if (w_addr_bad) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state    <= S_SETUP;
                        r_busy     <= 1'b1;
                        r_row_sel  <= w_row_oh;
                        r_col_sel  <= w_col_oh;
                        r_drv_mode <= w_op_new;
                        r_cnt      <= w_setup_ld;
                     end
                  end
               end
               S_SETUP: begin
                  if (r_cnt == 16'd0) begin
                     r_cnt <= w_pulse_ld;
                     if (r_op != 2'd0) begin
                        r_state       <= S_PULSE;
                        r_pulse_en    <= 1'b1;
                        r_pulses_used <= w_pu_inc;
                     end else begin
                        r_state    <= S_SENSE;
                        r_sense_en <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt - 16'd1;
                  end
               end
               S_PULSE, S_SENSE: begin
                  if (r_cnt == 16'd0) begin
                     if (r_state == S_SENSE)
                        r_sense_bit <= sense_in;
                     r_state    <= S_RECOVER;
                     r_pulse_en <= 1'b0;
                     r_sense_en <= 1'b0;
                     r_cnt      <= w_rec_ld;
                  end else begin
                     r_cnt <= r_cnt - 16'd1;
                  end
               end
               S_RECOVER: begin
                  if (r_cnt != 16'd0) begin
                     r_cnt <= r_cnt - 16'd1;
                  end else if (c_VERIFY && (r_op != 2'd0)) begin
                     r_state    <= S_VSENSE;
                     r_sense_en <= 1'b1;
                     r_drv_mode <= 2'd0;
                     r_cnt      <= w_pulse_ld;
                  end else begin
                     r_state    <= S_DONE;
                     r_row_sel  <= '0;
                     r_col_sel  <= '0;
                     r_drv_mode <= 2'd0;
                     r_done     <= 1'b1;
                     r_busy     <= 1'b0;
                  end
               end
               S_VSENSE: begin
                  if (r_cnt != 16'd0) begin
                     r_cnt <= r_cnt - 16'd1;
                  end else begin
                     r_sense_bit <= sense_in;
                     r_sense_en  <= 1'b0;
                     if (!w_sense_ok && (int'(r_pulses_used) < MAX_PULSES)) begin
                        r_state       <= S_PULSE;
                        r_pulse_en    <= 1'b1;
                        r_drv_mode    <= r_op;
                        r_cnt         <= w_pulse_ld;
                        r_pulses_used <= w_pu_inc;
                     end else begin
                        r_state       <= S_DONE;
                        r_verify_fail <= ~w_sense_ok;
                        r_row_sel     <= '0;
                        r_col_sel     <= '0;
                        r_drv_mode    <= 2'd0;
                        r_done        <= 1'b1;
                        r_busy        <= 1'b0;
                     end
                  end
               end
               S_DONE:  r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign row_sel   = r_row_sel;
   assign col_sel   = r_col_sel;
   assign drv_mode  = r_drv_mode;
   assign pulse_en  = r_pulse_en;
   assign sense_en  = r_sense_en;
   assign irq       = r_done & r_irq_en;

endmodule

`default_nettype wire

// File: doc/rram_pulse_sequencer.md
Name: rram_pulse_sequencer

Overview:
Wishbone-programmable sequencer that drives FORM/SET/RESET/READ operations on the RRAM test array inside the user analog area. It decodes a four-register window, runs a timed select/pulse/recover/sense state machine, drives one-hot row/column selects and driver-mode lines to the analog array, samples the sense comparator, and raises an interrupt on completion. It sits between the management SoC Wishbone port and the array drivers in the top-level wrapper.

Parameters:
ROWS, 8, number of word lines (one-hot row_sel width)
COLS, 8, number of bit lines (one-hot col_sel width)
BASE_ADDR, 32'h3000_0000, register window base; match on wbs_adr_i[31:4]
MAX_PULSES, 16, verify-loop pulse limit (RRAM_VERIFY_EN only)

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  asynchronous, active-high reset
wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe/cycle/write
wbs_sel_i  in  4  byte enables
wbs_adr_i  in  32  address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
row_sel  out  ROWS  one-hot word-line select
col_sel  out  COLS  one-hot bit-line select
drv_mode  out  2  0 read bias, 1 set, 2 reset, 3 form
pulse_en  out  1  program-pulse enable to array drivers
sense_en  out  1  sense amplifier enable
sense_in  in  1  comparator output (already synchronised in analog domain)
irq  out  1  level interrupt = done & irq_en

Behaviour:
- Reset: all outputs 0, FSM IDLE, all registers 0, busy=0.
- Wishbone: hit = stb&cyc&adr[31:4]==BASE_ADDR[31:4]; ack one cycle after hit, single-cycle pulse, never two consecutive; misses never acked. Writes honour wbs_sel_i per byte. Reads of unmapped offset return 0.
- 0x00 CTRL: [1:0] op, [2] start (write-1, self-clearing, reads 0), [3] abort (write-1, self-clearing), [4] irq_en.
- 0x04 ADDR: [7:0] row, [15:8] col.
- 0x08 TIMING: [15:0] pulse_w, [23:16] setup_w, [31:24] recover_w; value 0 treated as 1 cycle.
- 0x0C STATUS (RO except done W1C): [0] busy, [1] done, [2] aborted, [3] addr_err, [4] verify_fail, [15:8] pulses_used, [16] sense_bit.
- Writes to CTRL.op, ADDR, TIMING while busy are acked but discarded.
- FSM: IDLE -> SETUP (start seen; row_sel/col_sel/drv_mode driven; setup_w cycles) -> PULSE (op!=0: pulse_en=1 for pulse_w cycles) or SENSE (op=0: sense_en=1 for pulse_w cycles, sense_in captured into sense_bit on last cycle) -> RECOVER (selects held, enables low, recover_w cycles) -> DONE (one cycle: selects cleared, done=1, busy=0) -> IDLE.
- All outputs registered; pulse_en high exactly pulse_w cycles, starting the cycle after SETUP ends.
- start while busy ignored. start and abort in same write: abort wins, no operation.
- Range check at start: row>=ROWS or col>=COLS -> no SETUP, directly DONE with addr_err=1, no selects/pulse asserted.
- abort in any non-IDLE state: next cycle pulse_en/sense_en/selects low, aborted=1, done=1, FSM IDLE.
- New start clears aborted, addr_err, verify_fail, pulses_used; does not clear done (software W1C).
- pulses_used saturates at 255.

Optional Feature:
RRAM_VERIFY_EN: when defined, SET/RESET/FORM run program-and-verify: after RECOVER, an internal SENSE phase (drv_mode=0, pulse_w cycles) checks sense_bit (expect 1 for SET/FORM, 0 for RESET); mismatch re-enters PULSE until MAX_PULSES issued, then DONE with verify_fail=1. pulses_used counts issued pulses. When undefined, one pulse per operation, pulses_used=1, verify_fail reads 0.

Test Plan:
- Reset mid-PULSE (assert wb_rst_i async) -> pulse_en, row_sel, irq 0 immediately; STATUS reads 0.
- ADDR=0x0302, TIMING=0x02_03_0005, CTRL=0x15 (SET, start, irq_en) -> row_sel=8'h04, col_sel=8'h08, drv_mode=1, pulse_en high exactly 5 cycles after 3 setup cycles; done=1, irq=1, pulses_used=1.
- READ with sense_in=1, pulse_w=4 -> sense_en high 4 cycles, pulse_en never high, STATUS[16]=1; W1C done -> irq=0.
- ADDR row=9 with ROWS=8, start -> addr_err=1, done=1, no select/pulse ever asserted.
- Abort written 2 cycles into PULSE -> pulse_en low next cycle, aborted=1, done=1; start while busy ignored (no restart).
- RRAM_VERIFY_EN, SET, sense_in held 0, MAX_PULSES=16 -> 16 pulses, verify_fail=1, pulses_used=16; sense_in=1 after 3rd pulse -> pulses_used=3, verify_fail=0.
